// File: rtl/mpmc11_rmw_sequencer.sv
// Per-port command sequencer for the mpmc11 write-mask path.
// Define MPMC11_RMW_EN to expand partial-mask writes into read-modify-write.
module mpmc11_rmw_sequencer #(
    parameter int AW = 32,
    parameter int DW = 256,
    parameter int MW = DW / 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [MW-1:0] req_wmask,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [DW-1:0] resp_data,
    output logic          mem_cmd_valid,
    input  logic          mem_cmd_ready,
    output logic          mem_cmd_we,
    output logic [AW-1:0] mem_cmd_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [MW-1:0] mem_mask,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          rmw_busy,
    output logic          stray_rvalid
);

    typedef enum logic [2:0] {
        IDLE,
        RD_CMD,
        RD_WAIT,
        MERGE,
        WR_CMD,
        RESP
    } state_t;

    state_t        state;
    logic [MW-1:0] wmask_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          rmw_q;
    logic [DW-1:0] merged;

    always_comb begin
        merged = rdata_q;
        for (int i = 0; i < MW; i++) begin
            if (wmask_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            mem_cmd_valid <= 1'b0;
            mem_cmd_we    <= 1'b0;
            mem_cmd_addr  <= '0;
            mem_wdata     <= '0;
            mem_mask      <= '0;
            stray_rvalid  <= 1'b0;
            wmask_q       <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            rmw_q         <= 1'b0;
        end else begin
            if (mem_rvalid && state != RD_WAIT) stray_rvalid <= 1'b1;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready    <= 1'b0;
                        wmask_q      <= req_wmask;
                        wdata_q      <= req_wdata;
                        mem_cmd_addr <= req_addr;
                        mem_wdata    <= '0;
                        mem_mask     <= '0;
                        if (!req_we) begin
                            state         <= RD_CMD;
                            mem_cmd_valid <= 1'b1;
                            mem_cmd_we    <= 1'b0;
                        end else if (&req_wmask) begin
                            state         <= WR_CMD;
                            mem_cmd_valid <= 1'b1;
                            mem_cmd_we    <= 1'b1;
                            mem_wdata     <= req_wdata;
                        end else if (req_wmask == '0) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_data  <= '0;
                        end else begin
`ifdef MPMC11_RMW_EN
                            state         <= RD_CMD;
                            rmw_q         <= 1'b1;
                            mem_cmd_valid <= 1'b1;
                            mem_cmd_we    <= 1'b0;
`else
                            // Let the mask datapath suppress the unwritten lanes.
                            state         <= WR_CMD;
                            mem_cmd_valid <= 1'b1;
                            mem_cmd_we    <= 1'b1;
                            mem_wdata     <= req_wdata;
                            mem_mask      <= ~req_wmask;
`endif
                        end
                    end
                end
                RD_CMD: begin
                    if (mem_cmd_ready) begin
                        mem_cmd_valid <= 1'b0;
                        state         <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (mem_rvalid) begin
                        rdata_q <= mem_rdata;
                        if (rmw_q) begin
                            state <= MERGE;
                        end else begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_data  <= mem_rdata;
                        end
                    end
                end
                MERGE: begin
                    state         <= WR_CMD;
                    mem_cmd_valid <= 1'b1;
                    mem_cmd_we    <= 1'b1;
                    mem_wdata     <= merged;
                    mem_mask      <= '0;
                end
                WR_CMD: begin
                    if (mem_cmd_ready) begin
                        mem_cmd_valid <= 1'b0;
                        state         <= RESP;
                        resp_valid    <= 1'b1;
                        resp_data     <= '0;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        rmw_q      <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MPMC11_RMW_EN
    assign rmw_busy = rmw_q;
`else
    assign rmw_busy = 1'b0;
`endif

endmodule
